// File: rtl/clint_timer.sv
// clint_timer: memory-mapped machine timer and software-interrupt source.
//
// Holds a free-running 64-bit mtime, a 64-bit mtimecmp and a 1-bit msip, all
// reachable over a single-outstanding request/response bus. timer_intr is a
// registered level of (mtime >= mtimecmp); soft_intr follows msip directly.
//
// Register map (byte offsets, bits [1:0] of the address ignored):
//   0x00  msip (bit 0 only, other bits read 0)
//   0x08  mtimecmp[31:0]     0x0C  mtimecmp[63:32]
//   0x10  mtime[31:0]        0x14  mtime[63:32]
//   other offsets: read 0 / write ignored, resp_err = 1
//
// Ports:
//   clk_i          single clock, rising edge
//   rst_i          synchronous active-high reset
//   req_valid_i    request present
//   req_ready_o    block can accept a request (no response outstanding)
//   req_we_i       1 = write, 0 = read
//   req_addr_i     byte offset
//   req_wdata_i    write data
//   resp_valid_o   response present, held until resp_ready_i
//   resp_ready_i   requester consumes the response
//   resp_rdata_o   read data (0 for writes and unmapped reads)
//   resp_err_o     unmapped address
//   timer_intr_o   machine timer interrupt, level
//   soft_intr_o    machine software interrupt (= msip)
//
// Parameters:
//   PRESCALE   mtime advances once every PRESCALE clocks (1..65535)
//   RESET_CMP  reset value of mtimecmp
module clint_timer #(
    parameter int unsigned PRESCALE  = 1,
    parameter logic [63:0] RESET_CMP = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [4:0]  req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o,
    output logic        timer_intr_o,
    output logic        soft_intr_o
);

    // Word indices (byte offset >> 2) of the mapped registers.
    localparam logic [2:0] W_MSIP    = 3'd0;
    localparam logic [2:0] W_CMP_LO  = 3'd2;
    localparam logic [2:0] W_CMP_HI  = 3'd3;
    localparam logic [2:0] W_TIME_LO = 3'd4;
    localparam logic [2:0] W_TIME_HI = 3'd5;

    localparam logic [15:0] PCNT_LAST = 16'(PRESCALE - 1);

    logic [15:0] pcnt_q, pcnt_d;
    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic        msip_q, msip_d;
    logic        timer_intr_q, timer_intr_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;

    logic        tick;
    logic        accept;
    logic        wr_en;
    logic        mapped;
    logic [2:0]  word;
    logic [31:0] rd_val;

    // Address bits [1:0] carry no meaning for word-wide registers.
    logic        unused_addr_lsb;
    assign unused_addr_lsb = ^req_addr_i[1:0];

    assign word   = req_addr_i[4:2];
    assign accept = req_valid_i && !resp_valid_q;
    assign wr_en  = accept && req_we_i && mapped;
    assign tick   = (pcnt_q == PCNT_LAST);

    // Read mux sees pre-edge register contents, so a read accepted on a
    // tick edge returns the value from before that increment.
    always_comb begin
        rd_val = '0;
        mapped = 1'b1;
        case (word)
            W_MSIP:    rd_val = {31'b0, msip_q};
            W_CMP_LO:  rd_val = mtimecmp_q[31:0];
            W_CMP_HI:  rd_val = mtimecmp_q[63:32];
            W_TIME_LO: rd_val = mtime_q[31:0];
            W_TIME_HI: rd_val = mtime_q[63:32];
            default:   mapped = 1'b0;
        endcase
    end

    // Prescaler is never disturbed by software writes to mtime.
    always_comb begin
        pcnt_d = tick ? 16'd0 : pcnt_q + 16'd1;
    end

    // A software write to either half of mtime replaces that half and
    // suppresses the tick for this cycle; the other half keeps its old value.
    always_comb begin
        mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
        if (wr_en && word == W_TIME_LO) begin
            mtime_d = {mtime_q[63:32], req_wdata_i};
        end else if (wr_en && word == W_TIME_HI) begin
            mtime_d = {req_wdata_i, mtime_q[31:0]};
        end
    end

    always_comb begin
        mtimecmp_d = mtimecmp_q;
        msip_d     = msip_q;
        if (wr_en) begin
            case (word)
                W_MSIP:   msip_d             = req_wdata_i[0];
                W_CMP_LO: mtimecmp_d[31:0]  = req_wdata_i;
                W_CMP_HI: mtimecmp_d[63:32] = req_wdata_i;
                default:  ;
            endcase
        end
    end

    // Compare uses pre-edge values, giving one cycle of lag after a write.
    assign timer_intr_d = (mtime_q >= mtimecmp_q);

    always_comb begin
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        if (accept) begin
            resp_valid_d = 1'b1;
            resp_rdata_d = req_we_i ? 32'd0 : rd_val;
            resp_err_d   = !mapped;
        end else if (resp_valid_q && resp_ready_i) begin
            resp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pcnt_q       <= '0;
            mtime_q      <= '0;
            mtimecmp_q   <= RESET_CMP;
            msip_q       <= 1'b0;
            timer_intr_q <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            pcnt_q       <= pcnt_d;
            mtime_q      <= mtime_d;
            mtimecmp_q   <= mtimecmp_d;
            msip_q       <= msip_d;
            timer_intr_q <= timer_intr_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign req_ready_o  = !resp_valid_q;
    assign resp_valid_o = resp_valid_q;
    assign resp_rdata_o = resp_rdata_q;
    assign resp_err_o   = resp_err_q;
    assign timer_intr_o = timer_intr_q;
    assign soft_intr_o  = msip_q;

endmodule

// File: doc/clint_timer.md
# clint_timer

Memory-mapped machine timer and software-interrupt source that drives the core's `timer_intr` input. It holds a free-running 64-bit `mtime`, a 64-bit `mtimecmp` and a 1-bit `msip`, all accessed over a single-outstanding request/response bus. It raises a level interrupt when `mtime >= mtimecmp`. It sits beside the core at the top level, replacing bench-driven `timer_intr` stimulus with architecturally correct timer behaviour.

## Interface
- `PRESCALE`, default 1: `mtime` increments once every `PRESCALE` clocks. Legal range is 1..65535.
- `RESET_CMP`, default 64'hFFFF_FFFF_FFFF_FFFF: reset value of `mtimecmp`.
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept a request.
- `req_we` in 1: 1 = write, 0 = read.
- `req_addr` in 5: byte offset, word-aligned (bits [1:0] ignored).
- `req_wdata` in 32: write data.
- `resp_valid` out 1: response present.
- `resp_ready` in 1: requester consumes the response.
- `resp_rdata` out 32: read data; 0 for writes.
- `resp_err` out 1: unmapped address.
- `timer_intr` out 1: machine timer interrupt, level.
- `soft_intr` out 1: machine software interrupt, equal to `msip`.

## Operation
- Register map:
  - 0x00: `msip`, bit 0 only; other bits read 0.
  - 0x08 / 0x0C: `mtimecmp` lo / hi.
  - 0x10 / 0x14: `mtime` lo / hi.
  - All other offsets are unmapped: reads return 0 with `resp_err`=1, and writes are ignored with `resp_err`=1.
- Prescaler:
  - Counter `pcnt` counts 0..`PRESCALE`-1.
  - A tick occurs in the cycle `pcnt == PRESCALE-1`; `pcnt` then returns to 0.
  - With `PRESCALE`=1, every cycle is a tick.
- `mtime` increments by 1 on each tick and wraps from 2^64-1 to 0 with no flag.
- Software write to either half of `mtime`:
  - replaces that half only;
  - takes priority over a tick in the same cycle (no increment that cycle);
  - does not reset `pcnt`.
- 32-bit halves are written independently, with no atomic 64-bit update. Software must write `mtimecmp` hi = 0xFFFFFFFF first to avoid spurious interrupts.
- Reads return register contents at the accept edge, before that edge's increment.
- `timer_intr` is a register loaded every cycle with the unsigned 64-bit compare `mtime >= mtimecmp`, using pre-edge values.
- `soft_intr` is wired directly from the `msip` register.
- Bus rules:
  - `req_ready = !resp_valid` (one outstanding transaction).
  - Accept when `req_valid && req_ready`.
  - `resp_valid` rises the next cycle and holds, with `resp_rdata`/`resp_err` stable, until `resp_valid && resp_ready`.
  - A write takes effect at the accept edge.
- Reset (`rst`=1 at an edge) clears everything in one edge:
  - `mtime`=0, `mtimecmp`=`RESET_CMP`, `msip`=0, `pcnt`=0;
  - `timer_intr`=0, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0.
  - Any pending response is dropped. `req_ready`=1 after reset.

## Timing
- Request accepted at edge N: `resp_valid`=1 from N+1. If `resp_ready`=1 during N+1, the response completes at edge N+2, so peak throughput is one transaction per 2 cycles.
- Write to `mtimecmp` at edge N: the new compare is visible on `timer_intr` after edge N+1 (1-cycle lag).
- `PRESCALE`=P: with no writes, `mtime` is k after k·P edges from reset release.
- Tick and `mtime` write in the same cycle: the written value wins, and the next tick increments from it.
- `msip` write at edge N: `soft_intr` changes at N.
- `timer_intr` deasserts only when `mtimecmp` is raised above `mtime` or `mtime` wraps/is rewritten. It has no clear-on-read behaviour.
- `rst` asserted while `resp_valid`=1: `resp_valid`=0 after that edge, and the transaction is lost.

## Test plan
- Reset, then idle 10 cycles with `PRESCALE`=1 → read 0x10 returns 10 (±bus latency, exact value checked against edge count), 0x14 returns 0, `timer_intr`=0, `resp_err`=0.
- Write `mtimecmp` hi=0, lo=20 with `PRESCALE`=1 → `timer_intr` rises exactly one cycle after `mtime` reaches 20. Then write lo=1000 → `timer_intr` falls 1 cycle after the accept edge.
- `PRESCALE`=4, write `mtime` lo=0xFFFFFFFF, hi=0xFFFFFFFF, `mtimecmp`=0xFFFFFFFF_FFFFFFFF → `timer_intr`=1. After 4 more clocks `mtime` wraps to 0 and `timer_intr` returns to 0.
- Write `msip`=0xFFFF_FFFF → `soft_intr`=1 and read 0x00 returns 0x1. Write 0 → `soft_intr`=0.
- Read 0x04, then write 0x18 → `resp_err`=1 and `rdata`=0 for both; no register changes.
- Hold `resp_ready`=0 for 5 cycles with `req_valid`=1 → `req_ready`=0 and the response stays stable throughout. Assert `rst` mid-hold → `resp_valid`=0 and `req_ready`=1 on the next cycle.
